myproject_sdiv_22s_10s_16_seq: RTL and testbench

//  Sequential signed divider, the inverse of the 16s x 10s -> 22 DSP multiplier path.

---
 rtl/myproject_sdiv_22s_10s_16_seq.sv | 202 ++++++++++++++++++++
 tb/tb_myproject_sdiv_22s_10s_16_seq.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/myproject_sdiv_22s_10s_16_seq.sv
// Sequential signed restoring divider (22s / 10s -> 16s quotient, 10s remainder), start/done handshake.
// Optional: define MYPROJECT_SDIV_SAT_EN to saturate the quotient on overflow instead of wrapping.
module myproject_sdiv_22s_10s_16_seq #(
    parameter int ID         = 1,
    parameter int din0_WIDTH = 22,
    parameter int din1_WIDTH = 10,
    parameter int dout_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  ready,
    output logic                  done,
    output logic [dout_WIDTH-1:0] dout,
    output logic [din1_WIDTH-1:0] rem,
    output logic                  ovf,
    output logic                  dz
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    localparam int CW = $clog2(din0_WIDTH);
    localparam int MW = din0_WIDTH + 1;
    localparam int RW = din1_WIDTH + 1;
    localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);
    localparam logic [MW-1:0] QMAX = MW'((64'd1 << (dout_WIDTH - 1)) - 64'd1);
    localparam logic [MW-1:0] QMIN_MAG = MW'(64'd1 << (dout_WIDTH - 1));
    localparam logic [dout_WIDTH-1:0] DOUT_MAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] DOUT_MIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    // Magnitudes carry one extra bit so the most negative operand needs no special case.
    function automatic logic [MW-1:0] mag0(input logic [din0_WIDTH-1:0] v);
        logic [MW-1:0] ext;
        ext = {v[din0_WIDTH-1], v};
        if (v[din0_WIDTH-1]) begin
            mag0 = -ext;
        end else begin
            mag0 = ext;
        end
    endfunction

    function automatic logic [RW-1:0] mag1(input logic [din1_WIDTH-1:0] v);
        logic [RW-1:0] ext;
        ext = {v[din1_WIDTH-1], v};
        if (v[din1_WIDTH-1]) begin
            mag1 = -ext;
        end else begin
            mag1 = ext;
        end
    endfunction

    state_t                  state_r;
    logic [CW-1:0]           cnt_r;
    logic [din0_WIDTH-1:0]   dvd_r;
    logic [din1_WIDTH-1:0]   dvs_r;
    logic [RW-1:0]           part_r;
    logic [din0_WIDTH-1:0]   quo_r;
    logic                    sgn0_r;
    logic                    sgn1_r;
    logic                    dzp_r;
    logic                    ready_r;
    logic                    done_r;
    logic [dout_WIDTH-1:0]   dout_r;
    logic [din1_WIDTH-1:0]   rem_r;
    logic                    ovf_r;
    logic                    dz_r;

    logic [MW-1:0]           mag0_s;
    logic [RW-1:0]           mag1_s;
    logic [RW-1:0]           shift_s;
    logic                    ge_s;
    logic [RW-1:0]           sub_s;
    logic                    qneg_s;
    logic [MW-1:0]           qext_s;
    logic [MW-1:0]           qsig_s;
    logic                    ovf_s;
    logic [din1_WIDTH-1:0]   pmag_s;
    logic [din1_WIDTH-1:0]   rem_s;
    logic [dout_WIDTH-1:0]   dout_s;

    // Restoring step and sign/overflow fix-up datapath.
    always_comb begin
        mag0_s  = mag0(din0);
        mag1_s  = mag1(din1);
        shift_s = {part_r[din1_WIDTH-1:0], dvd_r[din0_WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, dvs_r});
        sub_s   = shift_s - {1'b0, dvs_r};
        qneg_s  = sgn0_r ^ sgn1_r;
        qext_s  = {1'b0, quo_r};
        if (qneg_s) begin
            qsig_s = -qext_s;
            ovf_s  = (qext_s > QMIN_MAG);
        end else begin
            qsig_s = qext_s;
            ovf_s  = (qext_s > QMAX);
        end
        pmag_s = part_r[din1_WIDTH-1:0];
        if (sgn0_r) begin
            rem_s = -pmag_s;
        end else begin
            rem_s = pmag_s;
        end
`ifdef MYPROJECT_SDIV_SAT_EN
        if (ovf_s) begin
            dout_s = qneg_s ? DOUT_MIN : DOUT_MAX;
        end else begin
            dout_s = qsig_s[dout_WIDTH-1:0];
        end
`else
        dout_s = qsig_s[dout_WIDTH-1:0];
`endif
    end

    // Control FSM, iteration registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            dvd_r   <= '0;
            dvs_r   <= '0;
            part_r  <= '0;
            quo_r   <= '0;
            sgn0_r  <= 1'b0;
            sgn1_r  <= 1'b0;
            dzp_r   <= 1'b0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            dout_r  <= '0;
            rem_r   <= '0;
            ovf_r   <= 1'b0;
            dz_r    <= 1'b0;
        end else if (ce) begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    ready_r <= 1'b1;
                    // ready_r is low in the cycle after done, so a start then is dropped.
                    if (start && ready_r) begin
                        ready_r <= 1'b0;
                        dvd_r   <= mag0_s[din0_WIDTH-1:0];
                        dvs_r   <= mag1_s[din1_WIDTH-1:0];
                        sgn0_r  <= din0[din0_WIDTH-1];
                        sgn1_r  <= din1[din1_WIDTH-1];
                        part_r  <= '0;
                        quo_r   <= '0;
                        cnt_r   <= '0;
                        dzp_r   <= (din1 == '0);
                        state_r <= (din1 == '0) ? FIX : CALC;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CALC: begin
                    dvd_r <= {dvd_r[din0_WIDTH-2:0], 1'b0};
                    if (ge_s) begin
                        part_r <= sub_s;
                        quo_r  <= {quo_r[din0_WIDTH-2:0], 1'b1};
                    end else begin
                        part_r <= shift_s;
                        quo_r  <= {quo_r[din0_WIDTH-2:0], 1'b0};
                    end
                    cnt_r   <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    state_r <= (cnt_r == LAST) ? FIX : CALC;
                end
                FIX: begin
                    if (dzp_r) begin
                        dout_r <= sgn0_r ? DOUT_MIN : DOUT_MAX;
                        rem_r  <= '0;
                        ovf_r  <= 1'b0;
                        dz_r   <= 1'b1;
                    end else begin
                        dout_r <= dout_s;
                        rem_r  <= rem_s;
                        ovf_r  <= ovf_s;
                        dz_r   <= 1'b0;
                    end
                    done_r  <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_r;
    assign done  = done_r;
    assign dout  = dout_r;
    assign rem   = rem_r;
    assign ovf   = ovf_r;
    assign dz    = dz_r;

endmodule

// File: tb/tb_myproject_sdiv_22s_10s_16_seq.sv
// Directed scoreboard bench for the sequential signed divider.
module tb_myproject_sdiv_22s_10s_16_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        start;
    logic [21:0] din0;
    logic [9:0]  din1;
    logic        ready;
    logic        done;
    logic [15:0] dout;
    logic [9:0]  rem;
    logic        ovf;
    logic        dz;

    int nvec  = 0;
    int nfail = 0;

    typedef struct {
        logic [15:0] dout;
        logic [9:0]  rem;
        logic        ovf;
        logic        dz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    myproject_sdiv_22s_10s_16_seq dut (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .start (start),
        .din0  (din0),
        .din1  (din1),
        .ready (ready),
        .done  (done),
        .dout  (dout),
        .rem   (rem),
        .ovf   (ovf),
        .dz    (dz)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: C-style truncating division on 32-bit ints.
    function automatic exp_t model(input int a, input int b, input int lat);
        exp_t e;
        int q;
        int r;
        logic [31:0] qv;
        e.lat = lat;
        if (b == 0) begin
            e.dout = (a >= 0) ? 16'h7FFF : 16'h8000;
            e.rem  = 10'd0;
            e.ovf  = 1'b0;
            e.dz   = 1'b1;
        end else begin
            q  = a / b;
            r  = a % b;
            qv = q;
            e.ovf = (q > 32767) || (q < -32768);
            e.dz  = 1'b0;
            qv    = r;
            e.rem = qv[9:0];
            qv    = q;
`ifdef MYPROJECT_SDIV_SAT_EN
            if (e.ovf) e.dout = (q < 0) ? 16'h8000 : 16'h7FFF;
            else       e.dout = qv[15:0];
`else
            e.dout = qv[15:0];
`endif
        end
        return e;
    endfunction

    task automatic do_div(input int a, input int b, input int lat,
                          input int pause_at, input int pause_len, input bit extra_start);
        exp_t e;
        int cyc;
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        sb.push_back(model(a, b, lat));
        din0  = av[21:0];
        din1  = bv[9:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        din0  = 22'h155555;
        din1  = 10'h2AA;
        check("ready_low_busy", {31'd0, ready}, 32'd0);
        cyc = 0;
        while (!done && cyc < 200) begin
            ce    = !(pause_len > 0 && cyc >= pause_at && cyc < pause_at + pause_len);
            start = extra_start && (cyc == 3);
            tick();
            cyc++;
        end
        ce    = 1'b1;
        start = 1'b0;
        e = sb.pop_front();
        check("done_seen", {31'd0, done}, 32'd1);
        check("latency", cyc, e.lat);
        check("dout", {16'd0, dout}, {16'd0, e.dout});
        check("rem", {22'd0, rem}, {22'd0, e.rem});
        check("ovf", {31'd0, ovf}, {31'd0, e.ovf});
        check("dz", {31'd0, dz}, {31'd0, e.dz});
        check("ready_low_on_done", {31'd0, ready}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("ready_after_done", {31'd0, ready}, 32'd1);
        check("start_on_done_ignored_hold", {16'd0, dout}, {16'd0, e.dout});
    endtask

    initial begin
        int ndone;
        reset = 1'b1;
        ce    = 1'b1;
        start = 1'b1;
        din0  = 22'd1000;
        din1  = 10'd7;
        tick();
        tick();
        start = 1'b0;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_dout", {16'd0, dout}, 32'd0);
        check("rst_rem", {22'd0, rem}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_dz", {31'd0, dz}, 32'd0);
        reset = 1'b0;
        tick();

        do_div(1000, 7, 23, 0, 0, 1'b0);
        do_div(-1000, 7, 23, 0, 0, 1'b0);
        do_div(1000, -7, 23, 0, 0, 1'b0);
        do_div(-1000, -7, 23, 0, 0, 1'b0);
        do_div(1048576, 1, 23, 0, 0, 1'b0);
        do_div(-2097152, -1, 23, 0, 0, 1'b0);
        do_div(5, 0, 1, 0, 0, 1'b0);
        do_div(-5, 0, 1, 0, 0, 1'b0);
        do_div(2097151, -512, 23, 0, 0, 1'b0);
        do_div(-229376, 7, 23, 0, 0, 1'b0);
        do_div(229376, 7, 23, 0, 0, 1'b0);
        do_div(-229383, 7, 23, 0, 0, 1'b0);
        do_div(1000, 7, 33, 5, 10, 1'b1);

        // Abort a division with reset at cycle 10.
        din0  = 22'd1000;
        din1  = 10'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_dout", {16'd0, dout}, 32'd0);
        check("abort_rem", {22'd0, rem}, 32'd0);
        check("abort_ovf", {31'd0, ovf}, 32'd0);
        check("abort_dz", {31'd0, dz}, 32'd0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);
        do_div(1000, 7, 23, 0, 0, 1'b0);

        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
